// File: rtl/act_index_stream_if.sv
// Row-in / beat-out handshake bundle for the activation index streamer.
// The master side supplies rows and consumes beats; the slave side is the streamer.
interface act_index_stream_if #(
    parameter int FLAG_W = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 8
) ();
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_mode;
    logic [FLAG_W-1:0]        in_flag;
    logic [FLAG_W*DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         out_idx;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic                     out_zero;
    logic [IDX_W:0]           row_val_num;

    modport master (
        output flush, in_valid, in_mode, in_flag, in_data, out_ready,
        input  in_ready, out_valid, out_idx, out_data, out_last, out_zero, row_val_num
    );

    modport slave (
        input  flush, in_valid, in_mode, in_flag, in_data, out_ready,
        output in_ready, out_valid, out_idx, out_data, out_last, out_zero, row_val_num
    );
endinterface

// File: rtl/act_index_stream.sv
// Sparse activation front end: takes one bitmap+data row per handshake and streams
// one (index, value) beat per set bitmap bit, lowest index first.
module act_index_stream #(
    parameter int FLAG_W = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    act_index_stream_if.slave bus
);

    typedef enum logic [0:0] {IDLE, EMIT} state_t;

    state_t                   state_reg, state_next;
    logic [FLAG_W-1:0]        mask_reg, mask_next;
    logic [FLAG_W*DATA_W-1:0] data_reg, data_next;
    logic [IDX_W:0]           row_val_num_reg, row_val_num_next;

    logic [DATA_W-1:0]        data_words [FLAG_W];
    logic [FLAG_W-1:0]        eff_mask;
    logic [IDX_W:0]           eff_pop;
    logic [IDX_W-1:0]         enc_idx;
    logic [FLAG_W-1:0]        mask_rest;
    logic                     beat_valid;
    logic                     beat_fire;
    logic                     beat_last;
    logic                     in_ready_int;
    logic                     load;

    genvar gi;
    generate
        for (gi = 0; gi < FLAG_W; gi++) begin : g_unpack
            assign data_words[gi] = data_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign eff_mask = bus.in_mode ? {FLAG_W{1'b1}} : bus.in_flag;

    always_comb begin
        eff_pop = '0;
        for (int i = 0; i < FLAG_W; i++) begin
            eff_pop = eff_pop + (IDX_W+1)'(eff_mask[i]);
        end
    end

    // Scanning from MSB down lets the lowest set bit win.
    always_comb begin
        enc_idx = '0;
        for (int i = FLAG_W - 1; i >= 0; i--) begin
            if (mask_reg[i]) begin
                enc_idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit; an empty result also marks the final beat,
    // which covers the zero row whose mask is already empty.
    assign mask_rest    = mask_reg & (mask_reg - FLAG_W'(1));
    assign beat_valid   = (state_reg == EMIT);
    assign beat_fire    = beat_valid & bus.out_ready;
    assign beat_last    = beat_valid & (mask_rest == '0);
    assign in_ready_int = ~bus.flush & ((state_reg == IDLE) | (beat_fire & beat_last));
    assign load         = bus.in_valid & in_ready_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = IDLE;
        end else if (load) begin
            state_next = EMIT;
        end else if (beat_fire && beat_last) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        mask_next        = mask_reg;
        data_next        = data_reg;
        row_val_num_next = row_val_num_reg;
        if (bus.flush) begin
            mask_next = '0;
        end else if (load) begin
            mask_next        = eff_mask;
            data_next        = bus.in_data;
            row_val_num_next = eff_pop;
        end else if (beat_fire) begin
            mask_next = mask_rest;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_reg        <= '0;
            data_reg        <= '0;
            row_val_num_reg <= '0;
        end else begin
            mask_reg        <= mask_next;
            data_reg        <= data_next;
            row_val_num_reg <= row_val_num_next;
        end
    end

    always_comb begin
        bus.out_valid   = beat_valid;
        bus.out_idx     = beat_valid ? enc_idx : '0;
        bus.out_data    = (beat_valid && (mask_reg != '0)) ? data_words[enc_idx] : '0;
        bus.out_last    = beat_last;
        bus.out_zero    = beat_valid & (mask_reg == '0);
        bus.in_ready    = in_ready_int;
        bus.row_val_num = row_val_num_reg;
    end

endmodule
